// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, default baud divisor and frame levels.
// Used by both the transmit framer and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // 50 MHz system clock at 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick_o at terminal count.
// Latency: tick_o is combinational from the counter register; no backpressure.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == TC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (cnt_q == TC) cnt_q <= '0;
            else             cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Latency: Tx falls on the accepting edge; Start is ignored while Busy (no queueing).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    uart_state_e state_q;
    logic [7:0]  sr_q;
    logic [2:0]  idx_q;
    logic        par_q;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic        baud_tick;

    // Counter is held at zero in IDLE so every bit slot starts from a clean count
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(state_q == ST_IDLE),
        .en_i   (state_q != ST_IDLE),
        .tick_o (baud_tick)
    );

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                    if (start_i) begin
                        sr_q    <= data_i;
                        par_q   <= (^data_i) ^ PARITY_ODD;
                        state_q <= ST_START;
                        tx_q    <= START_LEVEL;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_q <= ST_DATA;
                        idx_q   <= '0;
                        tx_q    <= sr_q[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        sr_q  <= sr_q >> 1;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= STOP_LEVEL;
                            end
                        end else begin
                            // Next bit is sr_q[1] because the shift lands on this same edge
                            tx_q <= sr_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        state_q <= ST_STOP;
                        tx_q    <= STOP_LEVEL;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        state_q <= ST_IDLE;
                        tx_q    <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three instances (no parity, even, odd) at 4 clocks per bit,
// expected line levels per bit slot queued at Start and popped while the frame is on the wire.
module tb_uart_tx_framer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    int         sel = 0;

    logic tx0, busy0, done0;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;
    logic tx_s, busy_s, done_s;

    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start && sel == 0), .data_i(data),
        .tx_o(tx0), .busy_o(busy0), .done_o(done0));

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_ev (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start && sel == 1), .data_i(data),
        .tx_o(tx1), .busy_o(busy1), .done_o(done1));

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_od (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start && sel == 2), .data_i(data),
        .tx_o(tx2), .busy_o(busy2), .done_o(done2));

    always_comb begin
        tx_s   = tx0;
        busy_s = busy0;
        done_s = done0;
        if (sel == 1) begin
            tx_s = tx1; busy_s = busy1; done_s = done1;
        end else if (sel == 2) begin
            tx_s = tx2; busy_s = busy2; done_s = done2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic kick(input logic [7:0] d);
        logic p;
        start = 1'b1;
        data  = d;
        p = ^d;
        if (sel == 2) p = ~p;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (sel != 0) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples every cycle of the frame; optionally pulses Start at cycle mid_at,
    // and optionally starts a second frame in the Done cycle.
    task automatic watch(input int mid_at, input logic [7:0] mid_d,
                         input bit b2b, input logic [7:0] b2b_d);
        int   nslots;
        logic e;
        nslots = (sel == 0) ? 10 : 11;
        for (int s = 0; s < nslots; s++) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("tx slot%0d", s), {31'd0, tx_s}, {31'd0, e});
                chk("busy_in_frame", {31'd0, busy_s}, 32'd1);
                chk("done_in_frame", {31'd0, done_s}, 32'd0);
                if (s * CPB + c == mid_at) begin
                    start = 1'b1;
                    data  = mid_d;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("busy_fall", {31'd0, busy_s}, 32'd0);
        chk("done_pulse", {31'd0, done_s}, 32'd1);
        chk("tx_idle_after", {31'd0, tx_s}, 32'd1);
        if (b2b) begin
            kick(b2b_d);
            chk("b2b_tx_start", {31'd0, tx_s}, 32'd0);
            watch(-1, 8'h00, 1'b0, 8'h00);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done_s}, 32'd0);
            chk("idle_busy", {31'd0, busy_s}, 32'd0);
            chk("idle_tx", {31'd0, tx_s}, 32'd1);
        end
    endtask

    initial begin
        // Reset held with Start pulsing on every instance
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = i[0];
            data  = 8'h5A;
            sel   = i % 3;
            chk("rst_tx",   {29'd0, tx0, tx1, tx2},       {29'd0, 3'b111});
            chk("rst_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
            chk("rst_done", {29'd0, done0, done1, done2}, 32'd0);
        end
        start = 1'b0;
        sel   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, no parity
        kick(8'hA5);
        watch(-1, 8'h00, 1'b0, 8'h00);

        // Start while busy is ignored
        kick(8'hA5);
        watch(10, 8'hFF, 1'b0, 8'h00);

        // Back-to-back: second Start in the Done cycle
        kick(8'hA5);
        watch(-1, 8'h00, 1'b1, 8'h3C);

        // Even then odd parity
        sel = 1;
        @(negedge clk);
        kick(8'h07);
        watch(-1, 8'h00, 1'b0, 8'h00);
        kick(8'hA5);
        watch(-1, 8'h00, 1'b0, 8'h00);
        sel = 2;
        @(negedge clk);
        kick(8'h07);
        watch(-1, 8'h00, 1'b0, 8'h00);

        // Mid-frame reset at cycle 17, then a clean frame
        sel = 0;
        @(negedge clk);
        kick(8'hA5);
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",   {31'd0, tx_s},   32'd1);
        chk("midrst_busy", {31'd0, busy_s}, 32'd0);
        chk("midrst_done", {31'd0, done_s}, 32'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("inrst_done", {31'd0, done_s}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", {31'd0, done_s}, 32'd0);
        kick(8'h01);
        watch(-1, 8'h00, 1'b0, 8'h00);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
